// File: rtl/hydra_pkg.sv
// Shared definitions for the port ingress front end: header field layout,
// FSM state encoding and the FIFO entry format.
package hydra_pkg;

    localparam int DATA_W     = 16;
    localparam int SRAM_IDX_W = 5;
    localparam int TIMER_W    = 8;

    // Header word layout: {len[15:7], prior[6:4], dest[3:0]}
    localparam int DEST_LSB  = 0;
    localparam int DEST_W    = 4;
    localparam int PRIOR_LSB = 4;
    localparam int PRIOR_W   = 3;
    localparam int LEN_LSB   = 7;
    localparam int LEN_W     = 9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_M_REQ   = 3'd1,
        ST_M_GUARD = 3'd2,
        ST_M_WAIT  = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DROP    = 3'd5
    } fe_state_t;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } fifo_word_t;

endpackage

// File: rtl/ingress_word_fifo.sv
// Synchronous first-word-fall-through FIFO holding {sop, eop, data} entries.
// The head entry is visible whenever the FIFO is non-empty; full is registered.
module ingress_word_fifo
    import hydra_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  fifo_word_t wr_word,
    input  logic       pop,
    output fifo_word_t head,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    fifo_word_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            full_q, full_d;
    logic            do_push, do_pop;

    // A push is only taken while not full; a pop only while non-empty.
    assign do_push = push && !full_q;
    assign do_pop  = pop && (count_q != '0);

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == (AW + 1)'(DEPTH));
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_word;
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = full_q;

endmodule

// File: rtl/port_ingress_frontend.sv
// Per-port ingress stage: buffers packet words, decodes the header, requests an
// SRAM match, then streams the payload tagged with the matched SRAM index.
// Downstream handshake: a word transfers on a cycle where xfer_vld && xfer_ready;
// while xfer_vld is high and xfer_ready low, xfer_data/xfer_last stay unchanged.
module port_ingress_frontend
    import hydra_pkg::*;
#(
    parameter int PORT_IDX      = 0,
    parameter int FIFO_DEPTH    = 64,
    parameter int MATCH_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_sop,
    input  logic                  wr_vld,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_eop,
    output logic                  wr_full,
    output logic                  match_enable,
    output logic [DEST_W-1:0]     new_dest_port,
    output logic [PRIOR_W-1:0]    new_prior,
    output logic [LEN_W-1:0]      new_length,
    input  logic                  match_end,
    input  logic [SRAM_IDX_W-1:0] matched_sram,
    output logic                  xfer_vld,
    output logic [DATA_W-1:0]     xfer_data,
    output logic [SRAM_IDX_W-1:0] xfer_sram,
    output logic                  xfer_last,
    input  logic                  xfer_ready,
    output logic                  err_pkt
);

    localparam logic [TIMER_W-1:0] TIMEOUT_T = TIMER_W'(MATCH_TIMEOUT);

    fifo_word_t               wr_word, head;
    logic                     fifo_empty, pop;
    fe_state_t                state_q, state_d;
    logic [DEST_W-1:0]        dest_q, dest_d;
    logic [PRIOR_W-1:0]       prior_q, prior_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [SRAM_IDX_W-1:0]    sram_q, sram_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic [TIMER_W-1:0]       timer_q, timer_d;
    logic [LEN_W-1:0]         word_no;
    logic [LEN_W-1:0]         hdr_len;

    assign wr_word = {wr_sop, wr_eop, wr_data};

    ingress_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_vld),
        .wr_word (wr_word),
        .pop     (pop),
        .head    (head),
        .empty   (fifo_empty),
        .full    (wr_full)
    );

    assign hdr_len = head.data[LEN_LSB +: LEN_W];
    assign word_no = cnt_q + 9'd1;

    // Next-state and output decode for the packet FSM.
    always_comb begin
        state_d      = state_q;
        dest_d       = dest_q;
        prior_d      = prior_q;
        len_d        = len_q;
        sram_d       = sram_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        pop          = 1'b0;
        match_enable = 1'b0;
        xfer_vld     = 1'b0;
        xfer_last    = 1'b0;
        err_pkt      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head.sop) begin
                        dest_d  = head.data[DEST_LSB +: DEST_W];
                        prior_d = head.data[PRIOR_LSB +: PRIOR_W];
                        len_d   = hdr_len;
                        if (hdr_len == '0) begin
                            err_pkt = 1'b1;
                            state_d = ST_DROP;
                        end else begin
                            state_d = ST_M_REQ;
                        end
                    end else begin
                        err_pkt = 1'b1;   // orphan payload word
                    end
                end
            end
            ST_M_REQ: begin
                match_enable = 1'b1;
                state_d      = ST_M_GUARD;
            end
            ST_M_GUARD: begin
                // match_end may still be high from the previous match here.
                timer_d = 8'd1;
                state_d = ST_M_WAIT;
            end
            ST_M_WAIT: begin
                if (match_end) begin
                    sram_d  = matched_sram;
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else if (timer_q >= TIMEOUT_T) begin
                    err_pkt = 1'b1;
                    state_d = ST_DROP;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (!fifo_empty) begin
                    if (head.sop) begin
                        err_pkt = 1'b1;   // next header arrived early; leave it for IDLE
                        state_d = ST_IDLE;
                    end else begin
                        xfer_vld  = 1'b1;
                        xfer_last = head.eop || (word_no == len_q);
                        if (xfer_ready) begin
                            pop   = 1'b1;
                            cnt_d = word_no;
                            if (head.eop) begin
                                err_pkt = (word_no != len_q);
                                state_d = ST_IDLE;
                            end else if (word_no == len_q) begin
                                err_pkt = 1'b1;   // extra words follow; discard to eop
                                state_d = ST_DROP;
                            end
                        end
                    end
                end
            end
            ST_DROP: begin
                if (!fifo_empty) begin
                    if (head.sop) begin
                        state_d = ST_IDLE;
                    end else begin
                        pop = 1'b1;
                        if (head.eop) state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, latched header fields, SRAM tag, word counter and match timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dest_q  <= '0;
            prior_q <= '0;
            len_q   <= '0;
            sram_q  <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            prior_q <= prior_d;
            len_q   <= len_d;
            sram_q  <= sram_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
        end
    end

    assign new_dest_port = dest_q;
    assign new_prior     = prior_q;
    assign new_length    = len_q;
    assign xfer_sram     = sram_q;
    assign xfer_data     = xfer_vld ? head.data : '0;

    a_enable_single: assert property (@(posedge clk) disable iff (rst)
        match_enable |=> !match_enable)
        else $error("port %0d: match_enable held longer than one cycle", PORT_IDX);

endmodule

// File: tb/tb_port_ingress_frontend.sv
`timescale 1ns/1ps
module tb_port_ingress_frontend;

  localparam int FIFO_DEPTH    = 64;
  localparam int MATCH_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_sop = 1'b0, wr_vld = 1'b0, wr_eop = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_full, match_enable;
  logic [3:0]  new_dest_port;
  logic [2:0]  new_prior;
  logic [8:0]  new_length;
  logic        match_end = 1'b0;
  logic [4:0]  matched_sram = '0;
  logic        xfer_vld, xfer_last, err_pkt;
  logic [15:0] xfer_data;
  logic [4:0]  xfer_sram;
  logic        xfer_ready = 1'b1;

  port_ingress_frontend #(
    .PORT_IDX(0), .FIFO_DEPTH(FIFO_DEPTH), .MATCH_TIMEOUT(MATCH_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .wr_sop(wr_sop), .wr_vld(wr_vld), .wr_data(wr_data),
    .wr_eop(wr_eop), .wr_full(wr_full), .match_enable(match_enable),
    .new_dest_port(new_dest_port), .new_prior(new_prior), .new_length(new_length),
    .match_end(match_end), .matched_sram(matched_sram), .xfer_vld(xfer_vld),
    .xfer_data(xfer_data), .xfer_sram(xfer_sram), .xfer_last(xfer_last),
    .xfer_ready(xfer_ready), .err_pkt(err_pkt)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait budget expired", name);
  endtask

  // ---------------- downstream ready pattern ----------------
  int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: never ready
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       xfer_ready = 1'b1;
      1:       xfer_ready = ~xfer_ready;
      default: xfer_ready = 1'b0;
    endcase
  end

  // ---------------- matcher model ----------------
  int         match_delay   = 5;
  logic [4:0] match_sram    = '0;
  bit         match_respond = 1'b1;
  always begin
    @(negedge clk);
    if (!rst && match_enable) begin
      @(posedge clk);
      @(posedge clk);
      #1 match_end = 1'b0;
      if (match_respond) begin
        repeat (match_delay) @(negedge clk);
        match_end    = 1'b1;
        matched_sram = match_sram;
      end
    end
  end

  // ---------------- monitor / scoreboard capture ----------------
  logic [21:0] exp_q[$];
  logic [21:0] got_q[$];
  int   en_cnt = 0, err_cnt = 0;
  int   en_cyc = -1, err_cyc = -1, first_x_cyc = -1;
  bit   full_seen = 1'b0;
  bit   stall_prev = 1'b0;
  logic        prev_last;
  logic [15:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (match_enable) begin en_cnt++; en_cyc = cyc; end
      if (err_pkt) begin err_cnt++; err_cyc = cyc; end
      if (wr_full) full_seen = 1'b1;
      if (xfer_vld && first_x_cyc < 0) first_x_cyc = cyc;
      if (stall_prev)
        chk("xfer_hold", {xfer_vld, xfer_last, xfer_data}, {1'b1, prev_last, prev_data});
      if (xfer_vld && xfer_ready) got_q.push_back({xfer_last, xfer_sram, xfer_data});
      stall_prev = xfer_vld && !xfer_ready;
      prev_last  = xfer_last;
      prev_data  = xfer_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic s, input logic e, input logic [15:0] d, output int acc_cyc);
    int g = 0;
    @(negedge clk);
    while (wr_full && g < 3000) begin
      wr_vld = 1'b0;
      @(negedge clk);
      g++;
    end
    if (g >= 3000) fail_timeout("push_wait");
    wr_vld  = 1'b1;
    wr_sop  = s;
    wr_eop  = e;
    wr_data = d;
    acc_cyc = cyc;
  endtask

  task automatic wr_idle();
    @(negedge clk);
    wr_vld = 1'b0;
    wr_sop = 1'b0;
    wr_eop = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    int g = 0;
    while (got_q.size() < n && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (got_q.size() < n) fail_timeout("wait_output_words");
  endtask

  task automatic clear_obs();
    en_cnt = 0; err_cnt = 0; en_cyc = -1; err_cyc = -1; first_x_cyc = -1;
    full_seen = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] dest;
    logic [2:0] prio;
    logic [8:0] len;
    int         nwords;   // payload words actually sent, eop on the last one
    int         delay;    // matcher response delay
    logic [4:0] sram;
    int         rdy;
    int         exp_en;   // expected match_enable pulses
    int         exp_out;  // expected transferred words
    int         exp_err;  // expected err_pkt pulses
  } vec_t;

  vec_t tbl[7];

  task automatic run_vec(input vec_t v, input int id);
    int hc, dc;
    logic [15:0] d;
    clear_obs();
    rdy_mode    = v.rdy;
    match_delay = v.delay;
    match_sram  = v.sram;
    push_word(1'b1, 1'b0, {v.len, v.prio, v.dest}, hc);
    for (int k = 1; k <= v.nwords; k++) begin
      d = 16'((id << 8) | k);
      push_word(1'b0, k == v.nwords, d, dc);
      if (k <= v.exp_out) exp_q.push_back({k == v.exp_out, v.sram, d});
    end
    wr_idle();
    wait_out(v.exp_out, 3000);
    repeat (10) @(negedge clk);
    chk($sformatf("v%0d_enable_pulses", id), en_cnt, v.exp_en);
    chk($sformatf("v%0d_err_pulses", id), err_cnt, v.exp_err);
    chk($sformatf("v%0d_out_count", id), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("v%0d_word%0d", id, i + 1), got_q[i], exp_q[i]);
    if (v.exp_en > 0) begin
      chk($sformatf("v%0d_hdr_to_enable", id), en_cyc - hc, 2);
      chk($sformatf("v%0d_new_dest", id), new_dest_port, v.dest);
      chk($sformatf("v%0d_new_prior", id), new_prior, v.prio);
      chk($sformatf("v%0d_new_length", id), new_length, v.len);
    end
    if (v.exp_out > 0)
      chk($sformatf("v%0d_match_to_xfer", id), first_x_cyc - en_cyc, v.delay + 2);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int g, dc;
    vec_t v;
    //          dest  prio  len     nw  dly  sram  rdy en out err
    tbl[0] = '{4'd3,  3'd2, 9'd4,   4,  10, 5'd7,  0,  1, 4,  0};  // basic packet
    tbl[1] = '{4'd5,  3'd7, 9'd2,   2,  6,  5'd19, 0,  1, 2,  0};  // stale match_end held
    tbl[2] = '{4'd1,  3'd1, 9'd5,   3,  8,  5'd2,  0,  1, 3,  1};  // eop early
    tbl[3] = '{4'd15, 3'd0, 9'd1,   1,  5,  5'd31, 0,  1, 1,  0};  // normal after error
    tbl[4] = '{4'd9,  3'd4, 9'd3,   5,  7,  5'd12, 0,  1, 3,  1};  // eop late
    tbl[5] = '{4'd6,  3'd5, 9'd69,  69, 80, 5'd23, 1,  1, 69, 0};  // fills FIFO, ready toggles
    tbl[6] = '{4'd2,  3'd3, 9'd0,   0,  5,  5'd1,  0,  0, 0,  1};  // zero length

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {wr_full, match_enable, new_dest_port, new_prior, new_length,
                          xfer_vld, xfer_data, xfer_sram, xfer_last, err_pkt}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i], i + 1);
      if (i == 5) chk("fifo_full_seen", full_seen, 1'b1);
    end

    // match timeout: payload dropped, err_pkt MATCH_TIMEOUT cycles into M_WAIT
    clear_obs();
    match_respond = 1'b0;
    push_word(1'b1, 1'b0, {9'd3, 3'd1, 4'd4}, dc);
    for (int k = 1; k <= 3; k++) push_word(1'b0, k == 3, 16'(16'h7700 + k), dc);
    wr_idle();
    g = 0;
    while (err_cnt == 0 && g < 600) begin @(negedge clk); g++; end
    if (err_cnt == 0) fail_timeout("timeout_err_wait");
    else chk("timeout_err_cycle", err_cyc - en_cyc, MATCH_TIMEOUT + 1);
    repeat (10) @(negedge clk);
    chk("timeout_enable_pulses", en_cnt, 1);
    chk("timeout_err_pulses", err_cnt, 1);
    chk("timeout_no_xfer", got_q.size(), 0);
    match_respond = 1'b1;

    // orphan payload word with no header
    clear_obs();
    push_word(1'b0, 1'b1, 16'hBEEF, dc);
    wr_idle();
    repeat (6) @(negedge clk);
    chk("orphan_err", err_cnt, 1);
    chk("orphan_no_enable", en_cnt, 0);

    // next packet after timeout is matched normally
    v = '{4'd7, 3'd6, 9'd2, 2, 9, 5'd5, 0, 1, 2, 0};
    run_vec(v, 8);

    // reset in the middle of DRAIN
    clear_obs();
    rdy_mode    = 2;
    match_delay = 5;
    match_sram  = 5'd9;
    push_word(1'b1, 1'b0, {9'd6, 3'd2, 4'd8}, dc);
    for (int k = 1; k <= 6; k++) push_word(1'b0, k == 6, 16'(16'h5500 + k), dc);
    wr_idle();
    g = 0;
    while (first_x_cyc < 0 && g < 300) begin @(negedge clk); g++; end
    if (first_x_cyc < 0) fail_timeout("drain_start_wait");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_outputs", {wr_full, match_enable, new_dest_port, new_prior, new_length,
                             xfer_vld, xfer_data, xfer_sram, xfer_last, err_pkt}, 64'd0);
    rst = 1'b0;
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    v = '{4'd10, 3'd3, 9'd3, 3, 6, 5'd14, 0, 1, 3, 0};
    run_vec(v, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
